// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared types and helpers for the data-memory responder.
// Revision : 1.0
// ============================================================================
package dmem_pkg;

    typedef enum logic [0:0] {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    localparam int WORD_SHIFT = 3;
    localparam int ADDR_CHK_W = 64;

    // Legal = doubleword aligned and no address bits above the word index.
    function automatic logic isLegal(input logic [ADDR_CHK_W-1:0] addr, input int addrW);
        return (addr[WORD_SHIFT-1:0] == '0) && ((addr >> (addrW + WORD_SHIFT)) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : dmem_init_seq
// Brief    : Post-reset zero-fill sequencer; walks every word index once.
// Revision : 1.0
// ============================================================================
module dmem_init_seq
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    output logic              init_busy,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_idx
);

    localparam logic [ADDR_W-1:0] c_lastIdx = '1;

    state_t            r_state;
    state_t            w_stateNext;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cntNext;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        fill_we     = 1'b0;
        case (r_state)
            S_INIT: begin
                fill_we   = 1'b1;
                w_cntNext = r_cnt + 1'b1;
                if (r_cnt == c_lastIdx) begin
                    w_stateNext = S_READY;
                end
            end
            S_READY: begin
                w_stateNext = S_READY;
            end
            default: begin
                w_stateNext = S_INIT;
            end
        endcase
    end

    assign fill_idx  = r_cnt;
    assign init_busy = (r_state == S_INIT);

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Data-memory responder with zero-fill, sticky fault capture and
//            a pipelined debug dump port.
// Revision : 1.0
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int N      = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              DM_writeEnable,
    input  logic              DM_readEnable,
    input  logic [N-1:0]      DM_addr,
    input  logic [N-1:0]      DM_writeData,
    output logic [N-1:0]      DM_readData,
    output logic              init_busy,
    input  logic              err_clr,
    output logic              align_err,
    output logic [N-1:0]      err_addr,
    input  logic              dump_req,
    input  logic [ADDR_W-1:0] dump_idx,
    output logic              dump_valid,
    output logic [N-1:0]      dump_data
);

    localparam int c_depth = 2 ** ADDR_W;

    logic [N-1:0]      r_mem [c_depth];
    logic              w_initBusy;
    logic              w_fillWe;
    logic [ADDR_W-1:0] w_fillIdx;
    logic [ADDR_W-1:0] w_wordIdx;
    logic              w_legal;
    logic              w_ready;
    logic              w_storeOk;
    logic              w_loadOk;
    logic              w_fault;
    logic              r_alignErr;
    logic [N-1:0]      r_errAddr;
    logic              r_dumpValid;
    logic [N-1:0]      r_dumpData;

    dmem_init_seq #(
        .ADDR_W (ADDR_W)
    ) u_initSeq (
        .clk       (clk),
        .reset     (reset),
        .init_busy (w_initBusy),
        .fill_we   (w_fillWe),
        .fill_idx  (w_fillIdx)
    );

    assign w_wordIdx = DM_addr[ADDR_W+WORD_SHIFT-1:WORD_SHIFT];
    assign w_legal   = isLegal(ADDR_CHK_W'(DM_addr), ADDR_W);
    assign w_ready   = !w_initBusy;
    assign w_storeOk = w_ready && DM_writeEnable && w_legal;
    assign w_loadOk  = w_ready && DM_readEnable && w_legal;
    assign w_fault   = w_ready && (DM_readEnable || DM_writeEnable) && !w_legal;

    // Fill and pipeline stores are mutually exclusive by state; fill takes priority anyway.
    always_ff @(posedge clk) begin
        if (w_fillWe) begin
            r_mem[w_fillIdx] <= '0;
        end else if (w_storeOk) begin
            r_mem[w_wordIdx] <= DM_writeData;
        end
    end

    assign DM_readData = w_loadOk ? r_mem[w_wordIdx] : '0;

    // A fault in the same cycle as err_clr re-arms the capture instead of clearing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alignErr <= 1'b0;
            r_errAddr  <= '0;
        end else if (w_fault && (!r_alignErr || err_clr)) begin
            r_alignErr <= 1'b1;
            r_errAddr  <= DM_addr;
        end else if (err_clr) begin
            r_alignErr <= 1'b0;
            r_errAddr  <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dumpValid <= 1'b0;
            r_dumpData  <= '0;
        end else begin
            r_dumpValid <= dump_req;
            r_dumpData  <= (dump_req && w_ready) ? r_mem[dump_idx] : '0;
        end
    end

    assign init_busy  = w_initBusy;
    assign align_err  = r_alignErr;
    assign err_addr   = r_errAddr;
    assign dump_valid = r_dumpValid;
    assign dump_data  = r_dumpData;

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder serving the pipeline's data-memory interface: write enable, read enable, byte address, write data in; read data out.
- Backed by a 2^ADDR_W-word array of N-bit doublewords.
- After reset, an init sequencer zero-fills the array one word per cycle.
- Flags misaligned and out-of-range accesses with a sticky error register.
- Exposes a one-cycle-latency debug dump port that benches use to inspect memory contents.

Parameters:
N, 64, data and address width in bits
ADDR_W, 6, word-index width; array depth is 2^ADDR_W doublewords

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
DM_writeEnable  in  1  store request from the MEM stage
DM_readEnable  in  1  load request from the MEM stage
DM_addr  in  N  byte address
DM_writeData  in  N  store data
DM_readData  out  N  load data, combinational, valid in the same cycle
init_busy  out  1  high while the zero-fill is in progress
err_clr  in  1  clears align_err and err_addr
align_err  out  1  sticky fault flag
err_addr  out  N  byte address of the first faulting access
dump_req  in  1  debug read request
dump_idx  in  ADDR_W  word index for the debug read
dump_valid  out  1  debug read data valid
dump_data  out  N  debug read data

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Word index = DM_addr[ADDR_W+2:3].
- An access is legal iff DM_addr[2:0]==0 and DM_addr[N-1:ADDR_W+3]==0.

FSM states:
- S_INIT: on the reset edge, go to S_INIT with cnt=0. Each cycle write 0 to mem[cnt], cnt++. After writing index 2^ADDR_W-1 (cnt wraps to 0), go to S_READY. Zero-fill therefore takes exactly 2^ADDR_W cycles after reset deasserts.
- S_READY: normal operation. Only reset leaves this state.
- Reset asserted mid-init restarts the fill at cnt=0.

Reset values (registered outputs, after the reset edge):
- init_busy=1
- align_err=0, err_addr=0
- dump_valid=0, dump_data=0

Loads:
- DM_readData = mem[idx] when DM_readEnable && S_READY && legal; otherwise 0.
- Asynchronous read. A same-cycle store to the same index is not visible until the next cycle (the load returns the old value).

Stores:
- On the edge, mem[idx] <= DM_writeData when DM_writeEnable && S_READY && legal.
- Stores during S_INIT are dropped silently and record no error.

Faults:
- In S_READY, (DM_readEnable || DM_writeEnable) && !legal suppresses the access.
- If align_err==0, set align_err=1 and err_addr=DM_addr. Later faults do not overwrite err_addr.
- err_clr clears both registers on the next edge.
- Fault and err_clr in the same cycle: the fault wins (align_err=1, err_addr captured).

Dump port:
- dump_req sampled at edge T produces dump_valid=1 and dump_data=mem[dump_idx] in cycle T+1. It is a single-cycle pulse, pipelined, so back-to-back requests are accepted every cycle.
- Read-before-write: a same-edge store to the same index returns the old value.
- During S_INIT, dump_data=0 and dump_valid still pulses.

Read enable and write enable both high: legal in this block; the load returns the old value and the store commits at the edge. No arbitration with the dump port; it is a separate read port.

Decomposition:
Shared package dmem_pkg holds:
- the state enum {S_INIT, S_READY}
- WORD_SHIFT=3
- the legality-check function (addr → legal bit), parameterised on ADDR_W

One sub-module is natural: dmem_init_seq, which owns the FSM and cnt and outputs init_busy, fill_we and fill_idx. The top muxes the fill write against pipeline stores.

Test Plan:
1. Init: assert reset 1 cycle with ADDR_W=6 → init_busy high exactly 64 cycles; load at 0x10 during init returns 0; afterwards dump of each of idx 0..63 returns 0.
2. Store/load: write 0xDEADBEEF_CAFEF00D to address 0x18, then read 0x18 → 0xDEADBEEF_CAFEF00D. Dump idx 3 → same value, dump_valid exactly one cycle after dump_req.
3. Same-cycle hazard: mem[2]=0x1111; store 0x2222 to address 0x10 while loading 0x10 → DM_readData=0x1111 that cycle, 0x2222 the next. A dump_req for idx 2 issued in the store cycle returns 0x1111.
4. Faults:
   - Load at 0x1C → DM_readData=0, align_err=1, err_addr=0x1C.
   - A following store at 0x200 leaves memory unchanged and err_addr stays 0x1C.
   - err_clr → align_err=0.
   - A fault coinciding with err_clr → align_err=1.
5. Reset mid-init: reassert reset at fill cycle 30 → init_busy stays high 64 more cycles. Values stored before the first reset read back as 0.
6. Dump streaming: dump_req held high for idx 0,1,2 on consecutive cycles after storing 0xA,0xB,0xC → dump_valid high 3 consecutive cycles carrying 0xA,0xB,0xC.
